// File: rtl/lfsr_interval_timer.sv
// lfsr_interval_timer: Galois-LFSR interval timer with periodic and one-shot modes
module lfsr_interval_timer #(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] SEED         = 32'hFFFF_FFFF,
  parameter logic [31:0] TAP_MASK     = 32'h0000_002D,
  parameter logic [31:0] TERM_DEFAULT = 32'h0000_6DB6,
  parameter int          CNT_W        = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             EnableCount,
  input  logic             Mode,
  input  logic             LoadTerm,
  input  logic [WIDTH-1:0] TermValue,
  output logic             TimerIndicator,
  output logic             Busy,
  output logic             Done,
  output logic             LoadErr,
  output logic [WIDTH-1:0] LfsrValue,
  output logic [CNT_W-1:0] TickCount
);
  localparam logic [WIDTH-1:0] seed_w = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] term_w = TERM_DEFAULT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] tap_w  = {TAP_MASK[WIDTH-1:1], 1'b0};
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;
  state_t           state;
  logic             mode_reg;
  logic [WIDTH-1:0] term_reg;
  logic [WIDTH-1:0] step;
  // one Galois step: rotate left, then fold the old MSB into the tapped bits
  always_comb step = {LfsrValue[WIDTH-2:0], LfsrValue[WIDTH-1]} ^ ({WIDTH{LfsrValue[WIDTH-1]}} & tap_w);
  // state machine; a match reloads SEED and counts in the same edge so there is no dead cycle
  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= IDLE;
      mode_reg       <= 1'b0;
      term_reg       <= term_w;
      LfsrValue      <= seed_w;
      TickCount      <= '0;
      TimerIndicator <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      LoadErr        <= 1'b0;
    end else begin
      LoadErr        <= LoadTerm && (state != IDLE || TermValue == '0);
      if (LoadTerm && state == IDLE && TermValue != '0) term_reg <= TermValue;
      TimerIndicator <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      LfsrValue      <= seed_w;
      case (state)
        IDLE:
          if (EnableCount) begin
            state     <= COUNT;
            Busy      <= 1'b1;
            mode_reg  <= Mode;
            TickCount <= '0;
          end
        COUNT:
          if (!EnableCount) state <= IDLE;
          else if (mode_reg && TimerIndicator) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            Busy <= 1'b1;
            if (LfsrValue == term_reg) begin
              TimerIndicator <= 1'b1;
              TickCount      <= TickCount + 1'b1;
            end else LfsrValue <= step;
          end
        DONE:
          if (EnableCount) Done <= 1'b1;
          else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_interval_timer.sv
// tb_lfsr_interval_timer: directed checks of the 4-bit timer against hand-computed sequences
module tb_lfsr_interval_timer;
  logic       clock, rst, EnableCount, Mode, LoadTerm;
  logic [3:0] TermValue;
  logic       TimerIndicator, Busy, Done, LoadErr;
  logic [3:0] LfsrValue;
  logic [3:0] TickCount;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] seq [15] = '{4'hF, 4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                           4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE};
  lfsr_interval_timer #(
    .WIDTH(4), .SEED(32'hF), .TAP_MASK(32'h3), .CNT_W(4)
  ) dut (
    .clock(clock), .rst(rst), .EnableCount(EnableCount), .Mode(Mode),
    .LoadTerm(LoadTerm), .TermValue(TermValue), .TimerIndicator(TimerIndicator),
    .Busy(Busy), .Done(Done), .LoadErr(LoadErr), .LfsrValue(LfsrValue),
    .TickCount(TickCount)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic load(input logic [3:0] v);
    LoadTerm = 1'b1;
    TermValue = v;
    tick;
    LoadTerm = 1'b0;
  endtask
  initial begin
    rst = 1'b1; EnableCount = 1'b0; Mode = 1'b0; LoadTerm = 1'b0; TermValue = '0;
    tick; tick;
    check("rst_lfsr", LfsrValue, 4'hF);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ti", TimerIndicator, 0);
    check("rst_err", LoadErr, 0);
    check("rst_cnt", TickCount, 0);
    rst = 1'b0;
    tick;
    EnableCount = 1'b1;
    tick;
    check("def_busy", Busy, 1);
    check("def_c0", LfsrValue, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("def_lfsr", LfsrValue, seq[i]);
      check("def_ti", TimerIndicator, 0);
    end
    tick;
    check("def_pulse", TimerIndicator, 1);
    check("def_reload", LfsrValue, 4'hF);
    check("def_cnt", TickCount, 1);
    EnableCount = 1'b0;
    tick;
    check("def_idle_busy", Busy, 0);
    check("def_idle_cnt", TickCount, 1);
    load(4'h2);
    check("load_ok_err", LoadErr, 0);
    EnableCount = 1'b1;
    tick;
    check("p_cnt0", TickCount, 0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 7) begin LoadTerm = 1'b1; TermValue = 4'h5; end
      tick;
      LoadTerm = 1'b0;
      check("p_lfsr", LfsrValue, (i % 5 == 0) ? 4'hF : seq[i % 5]);
      check("p_ti", TimerIndicator, i % 5 == 0);
      check("p_cnt", TickCount, i / 5);
      check("p_err", LoadErr, i == 7);
    end
    EnableCount = 1'b0;
    tick;
    check("p_idle_cnt", TickCount, 3);
    load(4'h0);
    check("zero_err", LoadErr, 1);
    tick;
    check("zero_err_clr", LoadErr, 0);
    EnableCount = 1'b1;
    tick;
    repeat (4) tick;
    check("zero_c4_lfsr", LfsrValue, 4'h2);
    check("zero_c4_ti", TimerIndicator, 0);
    tick;
    check("zero_ti", TimerIndicator, 1);
    repeat (4) tick;
    check("fall_match_lfsr", LfsrValue, 4'h2);
    EnableCount = 1'b0;
    tick;
    check("fall_ti", TimerIndicator, 0);
    check("fall_busy", Busy, 0);
    check("fall_lfsr", LfsrValue, 4'hF);
    check("fall_cnt", TickCount, 1);
    tick;
    check("fall_idle_ti", TimerIndicator, 0);
    load(4'h1);
    EnableCount = 1'b1;
    Mode = 1'b1;
    tick;
    Mode = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 6) begin LoadTerm = 1'b1; TermValue = 4'h3; end
      tick;
      LoadTerm = 1'b0;
      check("os_ti", TimerIndicator, i == 4);
      check("os_done", Done, i >= 5);
      check("os_busy", Busy, i <= 4);
      check("os_lfsr", LfsrValue, (i >= 4) ? 4'hF : seq[i]);
      check("os_err", LoadErr, i == 6);
    end
    check("os_cnt", TickCount, 1);
    EnableCount = 1'b0;
    tick;
    check("os_exit_done", Done, 0);
    check("os_exit_busy", Busy, 0);
    load(4'hF);
    EnableCount = 1'b1;
    tick;
    check("eq_c0_ti", TimerIndicator, 0);
    for (int i = 1; i <= 17; i++) begin
      tick;
      check("eq_ti", TimerIndicator, 1);
      check("eq_cnt", TickCount, i % 16);
      check("eq_lfsr", LfsrValue, 4'hF);
    end
    EnableCount = 1'b0;
    tick;
    load(4'h2);
    EnableCount = 1'b1;
    tick;
    repeat (3) tick;
    check("rm_pre_lfsr", LfsrValue, 4'h1);
    rst = 1'b1;
    tick;
    check("rm_ti", TimerIndicator, 0);
    check("rm_lfsr", LfsrValue, 4'hF);
    check("rm_cnt", TickCount, 0);
    check("rm_busy", Busy, 0);
    rst = 1'b0;
    tick;
    check("rm_ti2", TimerIndicator, 0);
    check("rm_busy2", Busy, 1);
    check("rm_c0", LfsrValue, 4'hF);
    repeat (8) tick;
    check("rm_c8_lfsr", LfsrValue, 4'h6);
    check("rm_c8_ti", TimerIndicator, 0);
    tick;
    check("rm_pulse", TimerIndicator, 1);
    EnableCount = 1'b0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_interval_timer.md
LFSR_INTERVAL_TIMER -- requirements
Module: lfsr_interval_timer

Interface
REQ-001 Parameter WIDTH, 16, LFSR and terminal-value width in bits (legal range 4..32).
REQ-002 Parameter SEED, all ones, LFSR start and reload value (SHALL be nonzero).
REQ-003 Parameter TAP_MASK, 16'h002D, Galois feedback mask.
REQ-004 Parameter TERM_DEFAULT, 16'h6DB6, terminal value after reset.
REQ-005 Parameter CNT_W, 8, width of the period counter.
REQ-006 Port clock  in  1  sole clock; all state updates on the rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port EnableCount  in  1  run request; level-sensitive.
REQ-009 Port Mode  in  1  0 = periodic, 1 = one-shot; sampled only on the IDLE->COUNT transition.
REQ-010 Port LoadTerm  in  1  single-cycle strobe that loads TermValue.
REQ-011 Port TermValue  in  WIDTH  new terminal value.
REQ-012 Port TimerIndicator  out  1  one-cycle pulse per elapsed interval.
REQ-013 Port Busy  out  1  high while in COUNT.
REQ-014 Port Done  out  1  high while in DONE.
REQ-015 Port LoadErr  out  1  one-cycle pulse when a load is rejected.
REQ-016 Port LfsrValue  out  WIDTH  current LFSR register.
REQ-017 Port TickCount  out  CNT_W  number of pulses issued since the last IDLE exit.

Function
REQ-018 LFSR step SHALL be: next[0] = L[WIDTH-1]; next[i] = L[i-1] XOR (TAP_MASK[i] AND L[WIDTH-1]) for i >= 1.
REQ-019 The state machine SHALL have exactly the states IDLE, COUNT and DONE; any illegal encoding SHALL go to IDLE on the next cycle.
REQ-020 IDLE: LFSR <= SEED, TimerIndicator = 0, Busy = 0, Done = 0; EnableCount = 1 -> COUNT next cycle, Mode latched, TickCount <= 0.
REQ-021 COUNT, no match: LFSR SHALL advance one step per cycle.
REQ-022 COUNT, match (LFSR == term_reg): the next cycle SHALL have TimerIndicator = 1, LFSR = SEED and TickCount + 1 (wraps modulo 2^CNT_W); there SHALL be no dead cycle.
REQ-023 Periodic period SHALL be k+1 cycles, where k = number of steps from SEED to term_reg; term_reg == SEED gives TimerIndicator high on every COUNT cycle.
REQ-024 One-shot match: after the pulse cycle the block SHALL be in DONE; DONE holds Done = 1, the LFSR frozen at SEED and TimerIndicator = 0.
REQ-025 DONE: EnableCount = 0 -> IDLE next cycle; otherwise the block stays in DONE.
REQ-026 EnableCount = 0 in COUNT -> IDLE next cycle; no pulse is issued even on a coincident match; TickCount is retained until the next IDLE exit.
REQ-027 LoadTerm SHALL be accepted only in IDLE with TermValue != 0, in which case term_reg <= TermValue next cycle.
REQ-028 LoadTerm in COUNT or DONE, or with TermValue == 0, SHALL leave term_reg unchanged and pulse LoadErr for one cycle.
REQ-029 If EnableCount and LoadTerm are both high in IDLE, the load SHALL take effect and the first COUNT cycle SHALL compare against the new value.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst = 1 at a clock edge SHALL force state = IDLE, LFSR = SEED, term_reg = TERM_DEFAULT, TickCount = 0, and TimerIndicator = Busy = Done = LoadErr = 0, overriding all other inputs.
REQ-032 Reset asserted mid-COUNT SHALL suppress any pending pulse; the first COUNT cycle after release requires EnableCount = 1 sampled in IDLE.

Verification (WIDTH=4, SEED=4'hF, TAP_MASK=4'h3, CNT_W=4; sequence F,D,9,1,2,4,8,3,6,C,B,5,A,7,E)
REQ-033 Load TermValue = 4'h2 in IDLE, then EnableCount = 1 in periodic mode -> LfsrValue F,D,9,1,2,F,...; TimerIndicator pulses every 5 cycles; TickCount = 1, 2, 3.
REQ-034 One-shot with TermValue = 4'h1 -> exactly one pulse 4 cycles after COUNT entry, then Done = 1 held; dropping EnableCount -> IDLE with Done = 0.
REQ-035 LoadTerm with TermValue = 4'h5 during COUNT -> LoadErr pulse, period unchanged at 5; LoadTerm with TermValue = 0 in IDLE -> LoadErr pulse, term_reg unchanged.
REQ-036 TermValue = 4'hF (equal to SEED), periodic -> TimerIndicator continuously 1, TickCount incrementing every cycle and wrapping 15 -> 0.
REQ-037 rst = 1 while LfsrValue = 4'h1 with term 4'h2 -> no pulse; after reset LfsrValue = F, term_reg = TERM_DEFAULT truncated to 4'h6, TickCount = 0.
REQ-038 EnableCount falling on the match cycle -> no TimerIndicator pulse; IDLE next cycle.
